// File: rtl/dot_product_accumulator.sv
// Reduction stage: sums num_terms unsigned products and returns the total over a valid/ready handshake.
// Build option: define DOT_ACC_SATURATE_EN to clamp the accumulator on carry-out instead of wrapping.
module dot_product_accumulator #(
  parameter  int PRODUCT_WIDTH = 64,
  parameter  int ACC_WIDTH     = 72,
  parameter  int MAX_TERMS     = 256,
  localparam int CNT_W         = $clog2(MAX_TERMS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_terms,
  output logic                     busy,
  input  logic [PRODUCT_WIDTH-1:0] product,
  input  logic                     product_valid,
  output logic [ACC_WIDTH-1:0]     result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     overflow
);

  generate
    if (ACC_WIDTH < PRODUCT_WIDTH) begin : g_width_check
      $error("ACC_WIDTH must be >= PRODUCT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]       r_remaining;
  logic [ACC_WIDTH-1:0]   r_result;
  logic                   r_result_valid;
  logic                   r_overflow;
  logic                   r_busy;

  logic                   w_load;
  logic                   w_load_empty;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_carry;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;

  // Once clamped, any further nonzero product carries again, so the clamp persists.
  function automatic logic [ACC_WIDTH-1:0] acc_update(input logic [ACC_WIDTH:0] sum);
`ifdef DOT_ACC_SATURATE_EN
    acc_update = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    acc_update = sum[ACC_WIDTH-1:0];
`endif
  endfunction

  assign w_sum     = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, product};
  assign w_carry   = w_sum[ACC_WIDTH];
  assign w_acc_nxt = acc_update(w_sum);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (num_terms == '0) ? S_HOLD : S_ACCUM;
      S_ACCUM: if (w_last) w_state_nxt = S_HOLD;
      S_HOLD:  if (result_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load       = 1'b0;
    w_load_empty = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load       = start;
        w_load_empty = start && (num_terms == '0);
      end
      S_ACCUM: begin
        w_accept = product_valid;
        w_last   = product_valid && (r_remaining == CNT_W'(1));
      end
      S_HOLD:  w_release = result_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc          <= '0;
      r_remaining    <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_load) begin
        r_acc       <= '0;
        r_overflow  <= 1'b0;
        r_remaining <= num_terms;
      end else if (w_accept) begin
        r_acc       <= w_acc_nxt;
        r_overflow  <= r_overflow | w_carry;
        r_remaining <= r_remaining - CNT_W'(1);
      end
      // result is a separate register so it survives the next operation's accumulator clear
      if (w_load_empty) begin
        r_result       <= '0;
        r_result_valid <= 1'b1;
      end else if (w_last) begin
        r_result       <= w_acc_nxt;
        r_result_valid <= 1'b1;
      end else if (w_release) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: vector table plus hand sequences, scoreboard on result_valid rising.
module tb_dot_product_accumulator;
  localparam int PW = 64;
  localparam int AW = 72;
  localparam int MT = 256;
  localparam int CW = $clog2(MT + 1);
  localparam int SCW = $clog2(4 + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_terms;
  logic          busy;
  logic [PW-1:0] product;
  logic          product_valid;
  logic [AW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          overflow;

  logic           s_start;
  logic [SCW-1:0] s_num_terms;
  logic           s_busy;
  logic [7:0]     s_product;
  logic           s_product_valid;
  logic [7:0]     s_result;
  logic           s_result_valid;
  logic           s_result_ready;
  logic           s_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [AW-1:0] res; logic ovf; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int                 n;
    logic [3:0][PW-1:0] p;
    int                 gap;
    int                 hold;
    logic [AW-1:0]      exp_res;
    logic               exp_ovf;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  dot_product_accumulator #(.PRODUCT_WIDTH(PW), .ACC_WIDTH(AW), .MAX_TERMS(MT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_terms(num_terms), .busy(busy),
    .product(product), .product_valid(product_valid), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .overflow(overflow)
  );

  dot_product_accumulator #(.PRODUCT_WIDTH(8), .ACC_WIDTH(8), .MAX_TERMS(4)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .num_terms(s_num_terms), .busy(s_busy),
    .product(s_product), .product_valid(s_product_valid), .result(s_result),
    .result_valid(s_result_valid), .result_ready(s_result_ready), .overflow(s_overflow)
  );

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input int n, input logic [AW-1:0] er, input logic eo);
    exp_t e;
    e.res = er;
    e.ovf = eo;
    sb_q.push_back(e);
    start     = 1'b1;
    num_terms = CW'(n);
    step();
    start     = 1'b0;
  endtask

  task automatic feed(input logic [PW-1:0] p);
    product_valid = 1'b1;
    product       = p;
    step();
    product_valid = 1'b0;
  endtask

  task automatic handshake(input string name);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check({name, "_rv_cleared"}, result_valid, 0);
    check({name, "_busy_cleared"}, busy, 0);
  endtask

  function automatic vec_t mk(input int n, input logic [PW-1:0] a, b, c, d,
                              input int gap, input int hold, input logic [AW-1:0] r, input logic o);
    vec_t v;
    v.n = n; v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.gap = gap; v.hold = hold; v.exp_res = r; v.exp_ovf = o;
    return v;
  endfunction

  // Scoreboard: compare on the rising edge of result_valid.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1 && !prev_rv) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got result %0h, expected no result", result);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", result, e.res);
        check("sb_overflow", overflow, e.ovf);
      end
    end
    prev_rv = (result_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] m;
    m = {PW{1'b1}};
    vecs[0] = mk(4, 64'd3, 64'd5, 64'd7, 64'd11, 0, 0, 72'd26, 1'b0);
    vecs[1] = mk(3, 64'd10, 64'd20, 64'd30, 64'd0, 2, 5, 72'd60, 1'b0);
    vecs[2] = mk(1, m, 64'd0, 64'd0, 64'd0, 0, 1, {8'h00, m}, 1'b0);
    vecs[3] = mk(2, m, m, 64'd0, 64'd0, 1, 0, 72'h1_FFFF_FFFF_FFFF_FFFE, 1'b0);
    vecs[4] = mk(0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 2, 72'd0, 1'b0);

    reset = 1'b0; start = 1'b0; num_terms = '0; product = '0; product_valid = 1'b0; result_ready = 1'b0;
    s_start = 1'b0; s_num_terms = '0; s_product = '0; s_product_valid = 1'b0; s_result_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", overflow, 0);
    check("rst_small_result", s_result, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      begin_op(vecs[i].n, vecs[i].exp_res, vecs[i].exp_ovf);
      for (int k = 0; k < vecs[i].n; k++) begin
        if (k > 0) repeat (vecs[i].gap) begin
          step();
          check($sformatf("v%0d_gap_busy", i), busy, 1);
        end
        if (k == vecs[i].n - 1) check($sformatf("v%0d_no_early_rv", i), result_valid, 0);
        feed(vecs[i].p[k]);
      end
      check($sformatf("v%0d_rv", i), result_valid, 1);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("v%0d_ovf", i), overflow, vecs[i].exp_ovf);
      check($sformatf("v%0d_busy", i), busy, 1);
      for (int h = 0; h < vecs[i].hold; h++) begin
        step();
        check($sformatf("v%0d_hold_rv", i), result_valid, 1);
        check($sformatf("v%0d_hold_result", i), result, vecs[i].exp_res);
      end
      handshake($sformatf("v%0d", i));
      check($sformatf("v%0d_result_kept", i), result, vecs[i].exp_res);
    end

    // product_valid in IDLE and HOLD must not disturb anything
    product = 64'd99; product_valid = 1'b1; step(); product_valid = 1'b0;
    check("idle_pv_busy", busy, 0);
    begin_op(0, 72'd0, 1'b0);
    check("empty_rv", result_valid, 1);
    feed(64'd77);
    check("hold_pv_result", result, 0);
    check("hold_pv_ovf", overflow, 0);
    check("hold_pv_rv", result_valid, 1);
    handshake("empty");

    // reset mid-operation abandons the reduction
    start = 1'b1; num_terms = CW'(5); step(); start = 1'b0;
    feed(64'd40);
    feed(64'd50);
    reset = 1'b0; step(); reset = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_rv", result_valid, 0);
    check("midrst_result", result, 0);
    begin_op(1, 72'd9, 1'b0);
    feed(64'd9);
    check("after_rst_result", result, 9);
    handshake("after_rst");

    // start coincident with result_ready is ignored; start one cycle later is taken
    begin_op(1, 72'd5, 1'b0);
    feed(64'd5);
    start = 1'b1; num_terms = CW'(1); result_ready = 1'b1;
    step();
    start = 1'b0; result_ready = 1'b0;
    check("coinc_busy", busy, 0);
    check("coinc_rv", result_valid, 0);
    begin_op(1, 72'd6, 1'b0);
    check("b2b_busy", busy, 1);
    feed(64'd6);
    check("b2b_result", result, 6);
    handshake("b2b");

    // narrow instance: 200 + 100 exceeds 8 bits
    s_start = 1'b1; s_num_terms = SCW'(2); step(); s_start = 1'b0;
    s_product_valid = 1'b1; s_product = 8'd200; step();
    s_product = 8'd100; step();
    s_product_valid = 1'b0;
    check("small_rv", s_result_valid, 1);
`ifdef DOT_ACC_SATURATE_EN
    check("small_result", s_result, 255);
`else
    check("small_result", s_result, 44);
`endif
    check("small_ovf", s_overflow, 1);
    s_result_ready = 1'b1; step(); s_result_ready = 1'b0;
    check("small_rv_cleared", s_result_valid, 0);

    step(); step();
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
